// File: rtl/rsa_modexp_decrypt.sv
// Sequential RSA decryption: plain = cipher^priv_key mod modulus.
// Constant-time right-to-left square-and-multiply using two bit-serial restoring reducers.
module rsa_modexp_decrypt #(
    parameter int WIDTH    = 16,
    parameter int EXP_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cipher,
    input  logic [WIDTH-1:0] priv_key,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] plain,
    output logic             err,
    output logic             busy
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(PW);
    localparam int CW = $clog2(EXP_BITS + 1);

    typedef enum logic [2:0] {IDLE, CHECK, PREP, REDUCE, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] c_q, d_q, n_q;
    logic [WIDTH-1:0] result, base, ebits;
    logic [PW-1:0]    pm, ps;
    logic [WIDTH:0]   rm, rs;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    bitcnt;

    logic             bad;
    logic             last_bit;
    logic [WIDTH:0]   n_ext, rm_sh, rs_sh, rm_nx, rs_nx;

    assign bad      = (n_q < WIDTH'(2)) || (c_q >= n_q);
    assign last_bit = (bitcnt == CW'(EXP_BITS - 1));
    assign n_ext    = {1'b0, n_q};

    // One restoring-division step per product bit; r < n keeps the shift within WIDTH+1 bits.
    always_comb begin
        rm_sh = {rm[WIDTH-1:0], pm[idx]};
        rs_sh = {rs[WIDTH-1:0], ps[idx]};
        rm_nx = (rm_sh >= n_ext) ? rm_sh - n_ext : rm_sh;
        rs_nx = (rs_sh >= n_ext) ? rs_sh - n_ext : rs_sh;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == PREP) || (state == REDUCE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CHECK;
            CHECK:   state_nx = bad ? DONE : PREP;
            PREP:    state_nx = REDUCE;
            REDUCE:  if (idx == '0) state_nx = last_bit ? DONE : PREP;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            d_q    <= '0;
            n_q    <= '0;
            result <= '0;
            base   <= '0;
            ebits  <= '0;
            pm     <= '0;
            ps     <= '0;
            rm     <= '0;
            rs     <= '0;
            idx    <= '0;
            bitcnt <= '0;
            plain  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_q <= cipher;
                        d_q <= priv_key;
                        n_q <= modulus;
                    end
                end
                CHECK: begin
                    if (bad) begin
                        plain <= '0;
                        err   <= 1'b1;
                    end else begin
                        result <= WIDTH'(1);
                        base   <= c_q;
                        ebits  <= d_q;
                        bitcnt <= '0;
                    end
                end
                PREP: begin
                    pm  <= PW'(result) * PW'(base);
                    ps  <= PW'(base) * PW'(base);
                    rm  <= '0;
                    rs  <= '0;
                    idx <= IW'(PW - 1);
                end
                REDUCE: begin
                    rm  <= rm_nx;
                    rs  <= rs_nx;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        // Multiply result is always computed; the exponent bit only selects whether it is kept.
                        if (ebits[0]) result <= rm_nx[WIDTH-1:0];
                        base   <= rs_nx[WIDTH-1:0];
                        ebits  <= ebits >> 1;
                        bitcnt <= bitcnt + CW'(1);
                        if (last_bit) begin
                            plain <= ebits[0] ? rm_nx[WIDTH-1:0] : result;
                            err   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Self-checking bench for rsa_modexp_decrypt: directed vector table, random jobs against
// a plain-arithmetic modular exponentiation model, plus backpressure and reset sequences.
module tb_rsa_modexp_decrypt;

    localparam int WIDTH    = 16;
    localparam int EXP_BITS = 16;
    localparam int LAT_OK   = 1 + EXP_BITS * (2 * WIDTH + 1);
    localparam int LAT_ERR  = 1;
    localparam int LIMIT    = 2000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] cipher = '0;
    logic [WIDTH-1:0] priv_key = '0;
    logic [WIDTH-1:0] modulus = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] plain;
    logic             err;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    rsa_modexp_decrypt #(.WIDTH(WIDTH), .EXP_BITS(EXP_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .cipher(cipher), .priv_key(priv_key), .modulus(modulus),
        .out_valid(out_valid), .out_ready(out_ready),
        .plain(plain), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c;
        int unsigned d;
        int unsigned n;
        int unsigned exp_plain;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: right-to-left binary exponentiation over 64-bit integers.
    function automatic void model(input int unsigned c, input int unsigned d, input int unsigned n,
                                  output int unsigned p, output bit e);
        longint unsigned r, b;
        if (n < 2 || c >= n) begin
            p = 0;
            e = 1'b1;
            return;
        end
        r = 1;
        b = c;
        for (int i = 0; i < EXP_BITS; i++) begin
            if (d[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        p = int'(r);
        e = 1'b0;
    endfunction

    task automatic run_job(input string tag, input int unsigned c, input int unsigned d,
                           input int unsigned n, input int unsigned exp_p, input bit exp_e);
        int lat;
        bit rdy_bad;
        logic busy_mid;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        cipher   = WIDTH'(c);
        priv_key = WIDTH'(d);
        modulus  = WIDTH'(n);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands must have been latched; scramble the bus.
        cipher   = WIDTH'($urandom);
        priv_key = WIDTH'($urandom);
        modulus  = WIDTH'($urandom);
        lat = 0;
        rdy_bad = 1'b0;
        busy_mid = 1'bx;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) rdy_bad = 1'b1;
            if (lat == 3) busy_mid = busy;
        end while (!out_valid && lat < LIMIT);
        check({tag, ".latency"}, lat, exp_e ? LAT_ERR : LAT_OK);
        check({tag, ".plain"}, plain, exp_p);
        check({tag, ".err"}, err, exp_e);
        check({tag, ".in_ready_low"}, rdy_bad, 0);
        if (!exp_e) check({tag, ".busy_mid"}, busy_mid, 1);
        check({tag, ".busy_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, ".valid_one_cycle"}, out_valid, 0);
        check({tag, ".in_ready_after"}, in_ready, 1);
    endtask

    vec_t vt[$];

    initial begin
        int unsigned c, d, n, p;
        bit e;
        bit unstable;
        logic [WIDTH-1:0] held;

        vt.push_back('{48,    103,   143,   9,     1'b0});
        vt.push_back('{2790,  2753,  3233,  65,    1'b0});
        vt.push_back('{65,    17,    3233,  2790,  1'b0});
        vt.push_back('{200,   103,   143,   0,     1'b1});
        vt.push_back('{5,     103,   1,     0,     1'b1});
        vt.push_back('{5,     103,   0,     0,     1'b1});
        vt.push_back('{5,     0,     143,   1,     1'b0});
        vt.push_back('{0,     103,   143,   0,     1'b0});
        vt.push_back('{65520, 65535, 65521, 65520, 1'b0});

        #2;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.plain", plain, 0);
        check("reset.err", err, 0);
        check("reset.busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i])
            run_job($sformatf("vec%0d", i), vt[i].c, vt[i].d, vt[i].n, vt[i].exp_plain, vt[i].exp_err);

        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(2, 65535);
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(n, 65535) : $urandom % n;
            d = $urandom_range(0, 65535);
            model(c, d, n, p, e);
            run_job($sformatf("rand%0d", k), c, d, n, p, e);
        end

        // Backpressure: result held for 50 cycles while a competing request is offered.
        @(negedge clk);
        cipher = 16'd48; priv_key = 16'd103; modulus = 16'd143;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t < LIMIT && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("bp.valid", out_valid, 1);
        held = plain;
        check("bp.plain", held, 9);
        @(negedge clk);
        cipher = 16'd2790; priv_key = 16'd2753; modulus = 16'd3233;
        in_valid = 1'b1;
        unstable = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (!out_valid || plain !== held || err !== 1'b0 || in_ready || busy) unstable = 1'b1;
        end
        check("bp.stable", unstable, 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release_valid", out_valid, 0);
        check("bp.release_ready", in_ready, 1);
        check("bp.release_busy", busy, 0);

        // Reset mid-job aborts silently.
        @(negedge clk);
        cipher = 16'd2790; priv_key = 16'd2753; modulus = 16'd3233;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (199) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.plain", plain, 0);
        check("rst.err", err, 0);
        check("rst.busy", busy, 0);
        unstable = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) unstable = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) unstable = 1'b1;
        end
        check("rst.no_output", unstable, 0);
        run_job("post_rst", 48, 103, 143, 9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_decrypt.md
Name: rsa_modexp_decrypt

Overview:
- Sequential RSA decryption engine: computes plain = cipher^priv_key mod modulus.
- Uses constant-time right-to-left square-and-multiply with a bit-serial modular reducer. No wide combinational divider.
- Sits downstream of the private-key generator and recovers plaintext from ciphertext produced by the encryption path.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand width of cipher, priv_key, modulus and plain.
- EXP_BITS, 16, number of exponent bits processed (LSB first); must be <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  cipher/priv_key/modulus valid
- in_ready  output  1  block can accept a job
- cipher  input  WIDTH  ciphertext C
- priv_key  input  WIDTH  private exponent d
- modulus  input  WIDTH  modulus n
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- plain  output  WIDTH  C^d mod n
- err  output  1  job rejected (bad operands); qualified by out_valid
- busy  output  1  exponentiation in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, plain=0, err=0, busy=0, all internal registers cleared.
- Reset asserted mid-operation aborts the job silently; no output is produced.
- Accept: a job is accepted on a rising edge where in_valid=1 and in_ready=1. C, d and n are latched on that edge.
- in_ready=1 only in IDLE. It is 0 while busy and while a result waits in DONE.
- States: IDLE, CHECK, PREP, REDUCE, DONE.
- IDLE -> CHECK on accept.
- CHECK (1 cycle):
  - If n<2 or C>=n: plain=0, err=1, go to DONE.
  - Else: result=1, base=C, ebits=d, bitcnt=0, busy=1, go to PREP.
- PREP (1 cycle):
  - Load product registers pm = result*base (2*WIDTH bits) and ps = base*base.
  - Clear both partial remainders rm and rs (WIDTH+1 bits). idx=2*WIDTH-1.
- REDUCE (2*WIDTH cycles): two restoring reducers run in parallel, one product bit per cycle.
  - r = (r<<1)|p[idx]; if r>=n then r = r-n; idx decrements.
  - The last cycle writes:
    - result = rm if ebits[0]=1, else result is unchanged.
    - base = rs.
    - ebits >>= 1; bitcnt++.
  - The multiply is always computed, even when the exponent bit is 0, so latency is constant and independent of d.
  - If bitcnt reaches EXP_BITS: plain=result, err=0, busy=0, go to DONE. Else go to PREP.
- DONE: out_valid=1; plain and err are held stable until out_ready=1. The handshake edge clears out_valid and returns to IDLE (in_ready=1 the next cycle).
- Latency, valid job: out_valid rises 1 + EXP_BITS*(2*WIDTH+1) edges after the accept edge. With defaults, 529 edges.
- Latency, rejected job: out_valid rises 1 edge after the accept edge.
- If out_ready is already 1 when DONE is entered, out_valid is high for exactly one cycle.
- Width rules:
  - Products are 2*WIDTH unsigned.
  - Remainders stay < n throughout.
  - Subtraction uses WIDTH+1 bits so nothing overflows at n near 2^WIDTH-1.
- d=0 yields plain=1 (n>=2). C=0 with d>0 yields plain=0.
- Input changes while not in IDLE are ignored.

Test Plan:
1. Reset, then C=48, d=103, n=143 (p=11, q=13) -> plain=9, err=0; out_valid exactly 529 edges after accept; in_ready=0 throughout.
2. C=2790, d=2753, n=3233 (p=61, q=53) -> plain=65; then back-to-back job C=65, d=17, n=3233 -> plain=2790; in_ready high one cycle after the first output handshake.
3. Error cases -> each gives out_valid 1 edge after accept with err=1, plain=0:
   - C=200, d=103, n=143.
   - n=1.
   - n=0.
4. Edge values:
   - d=0, C=5, n=143 -> plain=1.
   - C=0, d=103, n=143 -> plain=0.
   - n=65521, C=65520, d=65535 -> plain=65520 (-1 to an odd power).
5. Backpressure: hold out_ready=0 for 50 cycles after out_valid -> plain, err and out_valid stable; in_ready=0; a new in_valid is not accepted. Releasing out_ready completes the handshake.
6. Pull rst_n low at cycle 200 of a job -> outputs immediately reset to their reset values, no out_valid. After release, a new job C=48, d=103, n=143 yields 9.
